draw_spixel_rect: RTL and testbench

DRAW_SPIXEL_RECT -- requirements
Module: draw_spixel_rect

---
 rtl/draw_spixel_rect.sv | 175 +++++++++++++++++
 tb/tb_draw_spixel_rect.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/draw_spixel_rect.sv
// Superpixel rectangle rasteriser: scans a filled or outlined rectangle of
// SPIXEL_SIZE-square superpixels into a linear VGA frame-buffer write stream.
module draw_spixel_rect #(
  parameter int SPIXEL_X_WIDTH = 6,
  parameter int SPIXEL_Y_WIDTH = 6,
  parameter int SPIXEL_X_MAX   = 63,
  parameter int SPIXEL_Y_MAX   = 47,
  parameter int SPIXEL_SIZE    = 10,
  parameter int PIXEL_X_WIDTH  = 10,
  parameter int PIXEL_Y_WIDTH  = 9,
  parameter int H_PIXELS       = 640,
  parameter int VGA_ADDR_WIDTH = 19,
  parameter int COLOR_ID_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SPIXEL_X_WIDTH-1:0] x0,
  input  logic [SPIXEL_Y_WIDTH-1:0] y0,
  input  logic [SPIXEL_X_WIDTH-1:0] x1,
  input  logic [SPIXEL_Y_WIDTH-1:0] y1,
  input  logic [COLOR_ID_WIDTH-1:0] idata,
  input  logic                      imode,
  input  logic                      idata_vld,
  input  logic                      istall,
  output logic                      obusy,
  output logic                      odone,
  output logic [VGA_ADDR_WIDTH-1:0] oaddr,
  output logic [COLOR_ID_WIDTH-1:0] odata,
  output logic                      owren
);

  localparam int SXW = SPIXEL_X_WIDTH;
  localparam int SYW = SPIXEL_Y_WIDTH;
  localparam int PXW = PIXEL_X_WIDTH;
  localparam int PYW = PIXEL_Y_WIDTH;
  localparam int VAW = VGA_ADDR_WIDTH;

  localparam logic [PXW-1:0] SIZE_X  = PXW'(SPIXEL_SIZE);
  localparam logic [PYW-1:0] SIZE_Y  = PYW'(SPIXEL_SIZE);
  localparam logic [PYW:0]   SIZE_YE = (PYW+1)'(SPIXEL_SIZE);
  localparam logic [VAW-1:0] STRIDE  = VAW'(H_PIXELS);

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

  state_t                state;
  logic [SXW-1:0]        rx0, rx1;
  logic [SYW-1:0]        ry0, ry1;
  logic [COLOR_ID_WIDTH-1:0] rcolor;
  logic                  rmode;
  logic [PXW-1:0]        tlx, brx, px;
  logic [PYW-1:0]        tly, bry, py;
  logic [VAW-1:0]        row_base;

  logic [SXW-1:0]        cx0, cx1, xmin, xmax;
  logic [SYW-1:0]        cy0, cy1, ymin, ymax;
  logic [PXW-1:0]        s_tlx, s_brx;
  logic [PYW-1:0]        s_tly, s_bry;
  logic [VAW-1:0]        s_row;

  logic [PXW-1:0]        nx, jump_x, land_x;
  logic [PYW-1:0]        ny;
  logic [VAW-1:0]        nrow;
  logic                  last, inner_row;

  always_comb begin
    cx0   = (rx0 > SXW'(SPIXEL_X_MAX)) ? SXW'(SPIXEL_X_MAX) : rx0;
    cx1   = (rx1 > SXW'(SPIXEL_X_MAX)) ? SXW'(SPIXEL_X_MAX) : rx1;
    cy0   = (ry0 > SYW'(SPIXEL_Y_MAX)) ? SYW'(SPIXEL_Y_MAX) : ry0;
    cy1   = (ry1 > SYW'(SPIXEL_Y_MAX)) ? SYW'(SPIXEL_Y_MAX) : ry1;
    xmin  = (cx0 <= cx1) ? cx0 : cx1;
    xmax  = (cx0 <= cx1) ? cx1 : cx0;
    ymin  = (cy0 <= cy1) ? cy0 : cy1;
    ymax  = (cy0 <= cy1) ? cy1 : cy0;
    s_tlx = PXW'(xmin) * SIZE_X;
    s_tly = PYW'(ymin) * SIZE_Y;
    s_brx = (PXW'(xmax) + PXW'(1)) * SIZE_X - PXW'(1);
    s_bry = (PYW'(ymax) + PYW'(1)) * SIZE_Y - PYW'(1);
    s_row = VAW'(s_tly) * STRIDE;
  end

  // Outline rows strictly between the top and bottom superpixel rows skip the
  // interior by jumping from the left border's last column to the right border.
  always_comb begin
    jump_x    = tlx + SIZE_X - PXW'(1);
    land_x    = brx - SIZE_X + PXW'(1);
    inner_row = rmode && ({1'b0, py} >= ({1'b0, tly} + SIZE_YE))
                      && (({1'b0, py} + SIZE_YE) <= {1'b0, bry});
    last      = (px == brx) && (py == bry);
    nx        = px + PXW'(1);
    ny        = py;
    nrow      = row_base;
    if (px == brx) begin
      nx   = tlx;
      ny   = py + PYW'(1);
      nrow = row_base + STRIDE;
    end else if (inner_row && (px == jump_x)) begin
      nx = land_x;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rx0      <= '0;
      rx1      <= '0;
      ry0      <= '0;
      ry1      <= '0;
      rcolor   <= '0;
      rmode    <= 1'b0;
      tlx      <= '0;
      tly      <= '0;
      brx      <= '0;
      bry      <= '0;
      px       <= '0;
      py       <= '0;
      row_base <= '0;
      obusy    <= 1'b0;
      odone    <= 1'b0;
      oaddr    <= '0;
      odata    <= '0;
      owren    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (idata_vld) begin
            rx0    <= x0;
            ry0    <= y0;
            rx1    <= x1;
            ry1    <= y1;
            rcolor <= idata;
            rmode  <= imode;
            obusy  <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          tlx      <= s_tlx;
          tly      <= s_tly;
          brx      <= s_brx;
          bry      <= s_bry;
          px       <= s_tlx;
          py       <= s_tly;
          row_base <= s_row;
          oaddr    <= s_row + VAW'(s_tlx);
          odata    <= rcolor;
          owren    <= 1'b1;
          state    <= DRAW;
        end
        DRAW: begin
          if (!istall) begin
            if (last) begin
              owren <= 1'b0;
              oaddr <= '0;
              odata <= '0;
              odone <= 1'b1;
              state <= DONE;
            end else begin
              px       <= nx;
              py       <= ny;
              row_base <= nrow;
              oaddr    <= nrow + VAW'(nx);
            end
          end
        end
        DONE: begin
          odone <= 1'b0;
          obusy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_spixel_rect.sv
// Bench for draw_spixel_rect: directed corner cases plus random rectangles,
// each compared against a per-pixel model of which frame-buffer cells get painted.
module tb_draw_spixel_rect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  x0, x1;
  logic [5:0]  y0, y1;
  logic [7:0]  idata;
  logic        imode, idata_vld, istall;
  logic        obusy, odone, owren;
  logic [18:0] oaddr;
  logic [7:0]  odata;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int watch_addr = -1;

  draw_spixel_rect #(.SPIXEL_X_WIDTH(7), .SPIXEL_Y_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .idata(idata), .imode(imode), .idata_vld(idata_vld), .istall(istall),
    .obusy(obusy), .odone(odone), .oaddr(oaddr), .odata(odata), .owren(owren)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // A pixel is painted if fill mode, or its superpixel lies on the border ring.
  function automatic void build_model(input int ax0, ay0, ax1, ay1, md);
    int cx0, cx1, cy0, cy1, xmn, xmx, ymn, ymx, sx, sy;
    cx0 = (ax0 > 63) ? 63 : ax0;  cx1 = (ax1 > 63) ? 63 : ax1;
    cy0 = (ay0 > 47) ? 47 : ay0;  cy1 = (ay1 > 47) ? 47 : ay1;
    xmn = (cx0 < cx1) ? cx0 : cx1; xmx = (cx0 < cx1) ? cx1 : cx0;
    ymn = (cy0 < cy1) ? cy0 : cy1; ymx = (cy0 < cy1) ? cy1 : cy0;
    exp_q.delete();
    for (int y = ymn * 10; y < (ymx + 1) * 10; y++)
      for (int x = xmn * 10; x < (xmx + 1) * 10; x++) begin
        sx = x / 10;
        sy = y / 10;
        if (md == 0 || sx == xmn || sx == xmx || sy == ymn || sy == ymx)
          exp_q.push_back(y * 640 + x);
      end
  endfunction

  task automatic run_req(input int ax0, ay0, ax1, ay1, col, md,
                         input int stall_at, stall_len, input bit rnd_stall,
                         input bit poke, input int abort_at);
    int n, idx, cyc, stalls, hold, addr_err, data_err, done_early;
    int first_addr, last_addr, exp_watch, watch_hits, budget;
    bit finished, s;
    build_model(ax0, ay0, ax1, ay1, md);
    n = exp_q.size();
    exp_watch = 0;
    foreach (exp_q[i]) if (exp_q[i] == watch_addr) exp_watch++;
    idx = 0; cyc = 0; stalls = 0; hold = 0; addr_err = 0; data_err = 0;
    done_early = 0; first_addr = -1; last_addr = -1; watch_hits = 0;
    finished = 0; budget = 4 * n + 100;

    @(negedge clk);
    x0 = 7'(ax0); y0 = 6'(ay0); x1 = 7'(ax1); y1 = 6'(ay1);
    idata = 8'(col); imode = md[0]; idata_vld = 1'b1;
    @(negedge clk);
    idata_vld = 1'b0;
    check("setup_busy", obusy, 1);
    check("setup_wren", owren, 0);
    @(negedge clk);
    check("first_wren", owren, 1);
    check("draw_busy", obusy, 1);

    while (!finished && cyc < budget) begin
      if (!owren) begin
        finished = 1;
      end else begin
        if (idx >= n || oaddr != exp_q[idx]) addr_err++;
        if (odata != 8'(col)) data_err++;
        if (odone) done_early++;
        if (idx == 0 && first_addr < 0) first_addr = oaddr;
        last_addr = oaddr;
        if (abort_at == idx) begin
          rst_n = 1'b0;
          #1;
          check("rst_wren", owren, 0);
          check("rst_busy", obusy, 0);
          check("rst_addr", oaddr, 0);
          repeat (2) begin
            @(negedge clk);
            check("rst_done", odone, 0);
          end
          rst_n = 1'b1;
          istall = 1'b0;
          idata_vld = 1'b0;
          repeat (3) begin
            @(negedge clk);
            check("post_rst_quiet", {odone, owren, obusy}, 0);
          end
          return;
        end
        s = 1'b0;
        if (stall_at == idx && hold < stall_len) s = 1'b1;
        else if (rnd_stall) s = ($urandom_range(0, 7) == 0);
        istall = s;
        if (s) begin
          stalls++;
          if (stall_at == idx) hold++;
        end else begin
          if (oaddr == watch_addr) watch_hits++;
          idx++;
        end
        if (poke && cyc == 10) begin
          idata_vld = 1'b1;
          x0 = '0; y0 = '0; x1 = 7'd63; y1 = 6'd47; idata = ~idata; imode = ~imode;
        end else begin
          idata_vld = 1'b0;
        end
        cyc++;
        @(negedge clk);
      end
    end
    istall = 1'b0;
    idata_vld = 1'b0;
    check("no_timeout", finished, 1);
    check("done_pulse", odone, 1);
    check("done_busy", obusy, 1);
    check("writes", idx, n);
    check("draw_cycles", cyc, n + stalls);
    check("addr_errs", addr_err, 0);
    check("data_errs", data_err, 0);
    check("done_early", done_early, 0);
    check("first_addr", first_addr, exp_q[0]);
    check("last_addr", last_addr, exp_q[n-1]);
    if (stall_at >= 0) check("stall_held", hold, stall_len);
    if (watch_addr >= 0) check("watch_hits", watch_hits, exp_watch);
    check("done_addr", oaddr, 0);
    @(negedge clk);
    check("done_clear", odone, 0);
    check("idle_busy", obusy, 0);
    check("idle_wren", owren, 0);
  endtask

  initial begin
    rst_n = 1'b0; x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    idata = '0; imode = 1'b0; idata_vld = 1'b0; istall = 1'b0;
    #1;
    check("reset_busy", obusy, 0);
    check("reset_done", odone, 0);
    check("reset_wren", owren, 0);
    check("reset_addr", oaddr, 0);
    check("reset_data", odata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_req(0, 0, 0, 0, 'h5A, 0, -1, 0, 0, 0, -1);
    run_req(70, 50, 62, 46, 'h33, 0, -1, 0, 0, 0, -1);
    watch_addr = 16025;
    run_req(1, 1, 3, 3, 'hC3, 1, -1, 0, 0, 0, -1);
    run_req(3, 3, 1, 1, 'h3C, 0, -1, 0, 0, 0, -1);
    watch_addr = -1;
    run_req(5, 7, 6, 9, 'h11, 1, -1, 0, 0, 0, -1);
    run_req(2, 2, 2, 2, 'h77, 0, 4, 3, 0, 1, -1);
    run_req(0, 0, 0, 0, 'h5A, 0, -1, 0, 0, 0, 49);
    run_req(0, 0, 0, 0, 'h5A, 0, -1, 0, 0, 0, -1);

    for (int i = 0; i < 8; i++) begin
      int a, b, c, d;
      a = $urandom_range(0, 66);
      b = a + $urandom_range(0, 3);
      c = $urandom_range(0, 50);
      d = c + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1)
        run_req(b, d, a, c, $urandom_range(0, 255), $urandom_range(0, 1), -1, 0, 1, 1, -1);
      else
        run_req(a, c, b, d, $urandom_range(0, 255), $urandom_range(0, 1), -1, 0, 1, 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
